rs_codeword_shift_buf: RTL and testbench

Parametrised, registered successor to the decoder's two-symbol lane router. It collects one RS codeword of N symbols serially. It then drains the codeword LANES symbols per beat onto a W=LANES+1 lane window, with a per-frame ALIGN mode that places one zero-padding lane at the top or at the bottom. It sits between the symbol input stage and the multi-lane syndrome/correction datapath, with valid/ready handshakes on both sides.

---
 rtl/rs_pkg.sv | 17 +
 rtl/rs_lane_align.sv | 19 +
 rtl/rs_codeword_shift_buf.sv | 120 ++++++++++++
 tb/tb_rs_codeword_shift_buf.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared Reed-Solomon definitions: default code geometry, frame-buffer state encoding and the
// padding symbol.
package rs_pkg;

  localparam int unsigned SYM_W_DEF = 4;
  localparam int unsigned N_DEF     = 15;
  localparam int unsigned K_DEF     = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [SYM_W_DEF-1:0] ZERO_SYM = '0;

endpackage

// File: rtl/rs_lane_align.sv
// Places LANES symbols onto a LANES+1 lane window, with the single zero lane at the top
// (align=1) or at the bottom (align=0).
module rs_lane_align
  import rs_pkg::*;
#(
  parameter int unsigned SYM_W = SYM_W_DEF,
  parameter int unsigned LANES = 2
) (
  input  logic                       align,
  input  logic [LANES*SYM_W-1:0]     syms,
  output logic [(LANES+1)*SYM_W-1:0] lanes
);

  always_comb begin
    if (align) lanes = {SYM_W'(ZERO_SYM), syms};
    else       lanes = {syms, SYM_W'(ZERO_SYM)};
  end

endmodule

// File: rtl/rs_codeword_shift_buf.sv
// Collects one N-symbol codeword serially, then drains it LANES symbols per beat onto a
// LANES+1 lane window with valid/ready handshakes on both sides.
module rs_codeword_shift_buf
  import rs_pkg::*;
#(
  parameter int unsigned SYM_W = SYM_W_DEF,
  parameter int unsigned N     = N_DEF,
  parameter int unsigned LANES = 2,
  localparam int unsigned W     = LANES + 1,
  localparam int unsigned BEATS = (N + LANES - 1) / LANES
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               flush,
  input  logic               align,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SYM_W-1:0]   in_sym,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W*SYM_W-1:0] out_data,
  output logic               out_last,
  output logic               busy
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned BW = $clog2(BEATS + 1);

  state_t               state;
  logic [IW-1:0]        wr_idx;
  logic [BW-1:0]        beat_idx;
  logic                 align_q;
  logic [SYM_W-1:0]     mem [N];
  logic [LANES*SYM_W-1:0] beat_syms;
  logic [W*SYM_W-1:0]   beat_lanes;
  logic                 in_fire;
  int unsigned          idx;

  assign in_ready = RESET && (state == IDLE || state == FILL);
  assign busy     = (state != IDLE);
  assign in_fire  = in_valid && in_ready && !flush;

  // wr_idx is always 0 in IDLE, so one write port covers both IDLE and FILL.
  always_ff @(posedge CLK) begin
    if (in_fire) mem[wr_idx] <= in_sym;
  end

  // Gather the current beat; positions past the codeword end pad with zero.
  always_comb begin
    beat_syms = '0;
    idx       = 0;
    for (int unsigned k = 0; k < LANES; k++) begin
      idx = 32'(beat_idx) * LANES + k;
      if (idx < N) beat_syms[k*SYM_W +: SYM_W] = mem[idx[IW-1:0]];
    end
  end

  rs_lane_align #(
    .SYM_W (SYM_W),
    .LANES (LANES)
  ) u_lane_align (
    .align (align_q),
    .syms  (beat_syms),
    .lanes (beat_lanes)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      wr_idx    <= '0;
      beat_idx  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      align_q   <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      wr_idx    <= '0;
      beat_idx  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_fire) begin
            align_q <= align;
            wr_idx  <= IW'(1);
            state   <= FILL;
          end
        end
        FILL: begin
          if (in_fire) begin
            if (wr_idx == IW'(N - 1)) begin
              wr_idx   <= '0;
              beat_idx <= '0;
              state    <= DRAIN;
            end else begin
              wr_idx <= wr_idx + IW'(1);
            end
          end
        end
        DRAIN: begin
          if (out_valid && out_ready && out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            beat_idx  <= '0;
            state     <= IDLE;
          end else if ((!out_valid || out_ready) && beat_idx < BW'(BEATS)) begin
            out_data  <= beat_lanes;
            out_valid <= 1'b1;
            out_last  <= (beat_idx == BW'(BEATS - 1));
            beat_idx  <= beat_idx + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_codeword_shift_buf.sv
// Directed bench for rs_codeword_shift_buf at SYM_W=4, N=15, LANES=2.
module tb_rs_codeword_shift_buf;

  localparam int SYM_W = 4;
  localparam int N     = 15;
  localparam int LANES = 2;
  localparam int W     = LANES + 1;
  localparam int BEATS = 8;

  logic               CLK = 1'b0;
  logic               RESET = 1'b0;
  logic               flush = 1'b0;
  logic               align = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [SYM_W-1:0]   in_sym = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [W*SYM_W-1:0] out_data;
  logic               out_last;
  logic               busy;

  rs_codeword_shift_buf #(
    .SYM_W (SYM_W),
    .N     (N),
    .LANES (LANES)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .flush     (flush),
    .align     (align),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sym    (in_sym),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] data;
    logic        last;
  } beat_t;

  beat_t vec [24];
  int total = 0;
  int bad   = 0;
  int first_acc_cyc;
  int last_hs_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at #1 after a posedge; returns at #1 after the edge accepting the last symbol.
  task automatic send_frame(input int first, input int step, input int cnt, input bit al,
                            input bit toggle);
    for (int i = 0; i < cnt; i++) begin
      int g;
      in_valid = 1'b1;
      in_sym   = 4'(first + i * step);
      align    = (toggle && i >= 3) ? ~al : al;
      g = 0;
      while (!in_ready && g < 200) begin
        @(posedge CLK); #1;
        g++;
      end
      if (g >= 200) begin
        chk("in_ready_timeout", 32'(in_ready), 32'd1);
        return;
      end
      @(posedge CLK); #1;
      if (i == 0) first_acc_cyc = cyc;
    end
  endtask

  task automatic get_beats(input int base, input int stall_beat);
    for (int b = 0; b < BEATS; b++) begin
      int g;
      @(negedge CLK);
      g = 0;
      while (!out_valid && g < 20) begin
        @(negedge CLK);
        g++;
      end
      if (g >= 20) begin
        chk("out_valid_timeout", 32'(out_valid), 32'd1);
        return;
      end
      chk("in_ready_drain", 32'(in_ready), 32'd0);
      if (b == stall_beat) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge CLK);
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_data", 32'(out_data), 32'(vec[base+b].data));
        end
        out_ready = 1'b1;
      end
      chk($sformatf("beat%0d_data", base + b), 32'(out_data), 32'(vec[base+b].data));
      chk($sformatf("beat%0d_last", base + b), 32'(out_last), 32'(vec[base+b].last));
      @(posedge CLK); #1;
      if (b == BEATS - 1) last_hs_cyc = cyc;
    end
  endtask

  initial begin
    // 0..7: 1..15 align=1; 8..15: 1..15 align=0; 16..23: 15..1 align=1
    vec[0]  = '{12'h021, 1'b0}; vec[1]  = '{12'h043, 1'b0};
    vec[2]  = '{12'h065, 1'b0}; vec[3]  = '{12'h087, 1'b0};
    vec[4]  = '{12'h0A9, 1'b0}; vec[5]  = '{12'h0CB, 1'b0};
    vec[6]  = '{12'h0ED, 1'b0}; vec[7]  = '{12'h00F, 1'b1};
    vec[8]  = '{12'h210, 1'b0}; vec[9]  = '{12'h430, 1'b0};
    vec[10] = '{12'h650, 1'b0}; vec[11] = '{12'h870, 1'b0};
    vec[12] = '{12'hA90, 1'b0}; vec[13] = '{12'hCB0, 1'b0};
    vec[14] = '{12'hED0, 1'b0}; vec[15] = '{12'h0F0, 1'b1};
    vec[16] = '{12'h0EF, 1'b0}; vec[17] = '{12'h0CD, 1'b0};
    vec[18] = '{12'h0AB, 1'b0}; vec[19] = '{12'h089, 1'b0};
    vec[20] = '{12'h067, 1'b0}; vec[21] = '{12'h045, 1'b0};
    vec[22] = '{12'h023, 1'b0}; vec[23] = '{12'h001, 1'b1};

    // Reset values
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    @(negedge CLK); RESET = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Frame 1: align=1, with first-beat latency check
    send_frame(1, 1, N, 1'b1, 1'b0);
    in_valid = 1'b0;
    chk("lat_t1_valid", 32'(out_valid), 32'd0);
    chk("lat_t1_busy", 32'(busy), 32'd1);
    @(posedge CLK); #1;
    chk("lat_t2_valid", 32'(out_valid), 32'd1);
    get_beats(0, -1);

    // Frame 2: align=0
    send_frame(1, 1, N, 1'b0, 1'b0);
    in_valid = 1'b0;
    get_beats(8, -1);

    // Frame 3: align toggled after 3rd symbol, plus backpressure at beat 4
    send_frame(1, 1, N, 1'b1, 1'b1);
    in_valid = 1'b0;
    get_beats(0, 4);
    @(negedge CLK);
    chk("idle_after_frame", 32'(busy), 32'd0);

    // Flush mid-FILL, then a fresh descending frame
    send_frame(9, 1, 6, 1'b0, 1'b0);
    in_valid = 1'b0;
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    send_frame(15, -1, N, 1'b1, 1'b0);
    in_valid = 1'b0;
    get_beats(16, -1);

    // Reset mid-DRAIN
    send_frame(1, 1, N, 1'b1, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge CLK); @(negedge CLK);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    RESET = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    out_ready = 1'b1;
    @(negedge CLK);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);
    @(posedge CLK); #1;

    // Back-to-back frames with in_valid held high
    fork
      begin
        send_frame(1, 1, N, 1'b1, 1'b0);
        send_frame(15, -1, N, 1'b1, 1'b0);
        in_valid = 1'b0;
      end
      begin
        get_beats(0, -1);
        begin
          int hs;
          hs = last_hs_cyc;
          get_beats(16, -1);
          chk("b2b_gap", 32'(first_acc_cyc - hs), 32'd1);
        end
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
